aes_word_adapter: RTL
=====================

AES_WORD_ADAPTER -- requirements
Module: aes_word_adapter

Interface
REQ-001 Parameter: DATA_WIDTH, 128, AES block/key width.
REQ-002 Parameter: WORD_WIDTH, 32, stream word width; DATA_WIDTH/WORD_WIDTH = 4 words per block (NW).
REQ-003 Parameter: TIMEOUT, 64, max cycles waited for core done.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  input word valid.
REQ-008 in_ready  out  1  input word accepted when in_valid&in_ready.
REQ-009 in_data  in  WORD_WIDTH  key or data word, MSB word first.
REQ-010 in_is_key  in  1  1 = word is key, 0 = word is data.
REQ-011 in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with last data word.
REQ-012 out_valid  out  1  result word valid.
REQ-013 out_ready  in  1  downstream accepts result word.
REQ-014 out_data  out  WORD_WIDTH  result word, MSB word first.
REQ-015 busy  out  1  high in every state except LOAD.
REQ-016 err_timeout  out  1  sticky timeout flag, cleared on next start pulse.
REQ-017 start_encryption, start_decryption  out  1 each  one-cycle start pulses to AES core.
REQ-018 plaintext_encryption, cyphertext_decryption, key_encryption  out  DATA_WIDTH each  core operands.
REQ-019 cyphertext_encryption, plaintext_decryption  in  DATA_WIDTH each  core results.
REQ-020 done_encryption, done_decyption  in  1 each  core completion strobes.

Function
REQ-021 FSM states SHALL be LOAD, START, WAIT, DRAIN; reset state LOAD.
REQ-022 LOAD: in_ready=1; key word -> key_reg word[key_cnt], key_cnt++; data word -> data_reg word[data_cnt], data_cnt++; word 0 = bits [127:96].
REQ-023 Key word accepted when key_cnt==NW SHALL restart key load (written to word 0, key_cnt=1).
REQ-024 Data words beyond NW SHALL not be accepted; in_ready=0 once data_cnt==NW and key_cnt<NW.
REQ-025 LOAD->START when data_cnt==NW and key_cnt==NW; mode latched from in_mode on the accepting cycle of data word NW-1.
REQ-026 START (one cycle): in_ready=0; start_encryption=1 if mode=0 else start_decryption=1; err_timeout cleared; -> WAIT.
REQ-027 plaintext_encryption and cyphertext_decryption SHALL both equal data_reg; key_encryption SHALL equal key_reg; all stable from START until return to LOAD.
REQ-028 WAIT: only the done matching mode counts; on it capture matching result into out_reg, -> DRAIN; other done ignored.
REQ-029 WAIT timer counts cycles; at TIMEOUT with no matching done: err_timeout=1, data_cnt=0, -> LOAD (key retained).
REQ-030 Done strobes outside WAIT SHALL be ignored.
REQ-031 DRAIN: out_valid=1, out_data=out_reg word[out_cnt]; out_cnt++ on out_ready; after word NW-1 accepted: data_cnt=0, out_cnt=0, -> LOAD.
REQ-032 out_data/out_valid SHALL hold while out_valid&!out_ready.
REQ-033 Latency: last operand word accepted cycle N -> start pulse cycle N+1; matching done cycle M -> out_valid cycle M+1.
REQ-034 Key SHALL persist across blocks; subsequent blocks need only NW data words.

Reset
REQ-035 rst low SHALL asynchronously force: state LOAD, all counters 0, key_reg/data_reg/out_reg 0, start pulses 0, out_valid 0, busy 0, err_timeout 0, core operand outputs 0.
REQ-036 Reset mid-WAIT or mid-DRAIN SHALL discard the block and key; no start pulse or output word after release until full key+data reload.

Verification
REQ-037 Key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, mode 0, core model -> one start_encryption pulse, out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
REQ-038 Same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 -> one start_decryption pulse, out words 00112233, 44556677, 8899aabb, ccddeeff.
REQ-039 Second block without key reload -> start pulse after 4 data words, key_encryption unchanged.
REQ-040 Core never asserts done -> err_timeout=1 exactly TIMEOUT cycles after WAIT entry, busy=0, in_ready=1; next start clears err_timeout.
REQ-041 out_ready held low 10 cycles in DRAIN, also done_decyption strobed in encrypt WAIT -> out_data stable, strobe ignored, four words in order.
REQ-042 rst asserted during WAIT -> all outputs 0 immediately; data-only load afterward yields no start pulse.

Source files
------------

// File: rtl/aes_word_adapter.sv
// ---------------------------------------------------------------------------
// aes_word_adapter
//
// Adapts a 32-bit word stream to a 128-bit AES core. Key and data words are
// collected MSB word first, the core gets a one-cycle start pulse (encrypt or
// decrypt), and its 128-bit result is streamed back out as four words.
// The key is kept across blocks, so later blocks only need four data words.
//
// Ports
//   clk                     system clock, rising edge
//   rst                     asynchronous reset, active low
//   in_valid/in_ready       input word handshake
//   in_data                 key or data word, MSB word first
//   in_is_key               1 = key word, 0 = data word
//   in_mode                 0 = encrypt, 1 = decrypt (taken with last data word)
//   out_valid/out_ready     result word handshake
//   out_data                result word, MSB word first
//   busy                    high whenever not collecting input
//   err_timeout             sticky core timeout flag, cleared on next start
//   start_encryption/_decryption   one-cycle start pulses to the core
//   plaintext_encryption, cyphertext_decryption, key_encryption  core operands
//   cyphertext_encryption, plaintext_decryption                  core results
//   done_encryption, done_decyption                              core done strobes
// ---------------------------------------------------------------------------
module aes_word_adapter #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_is_key,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  start_encryption,
  output logic                  start_decryption,
  output logic [DATA_WIDTH-1:0] plaintext_encryption,
  output logic [DATA_WIDTH-1:0] cyphertext_decryption,
  output logic [DATA_WIDTH-1:0] key_encryption,
  input  logic [DATA_WIDTH-1:0] cyphertext_encryption,
  input  logic [DATA_WIDTH-1:0] plaintext_decryption,
  input  logic                  done_encryption,
  input  logic                  done_decyption
);

  localparam int NW    = DATA_WIDTH / WORD_WIDTH;
  localparam int CNT_W = $clog2(NW + 1);
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] NW_C      = CNT_W'(NW);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NW - 1);
  localparam logic [IDX_W-1:0] LAST_OUT  = IDX_W'(NW - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      keyCnt_q, dataCnt_q;
  logic [CNT_W-1:0]      keyCnt_d, dataCnt_d;
  logic [IDX_W-1:0]      outCnt_q;
  logic [TMR_W-1:0]      timer_q;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] keyReg_q, dataReg_q, outReg_q;
  logic                  startEnc_q, startDec_q, errTimeout_q;

  logic                  keyFull, dataFull, loadReady;
  logic                  keyAccept, dataAccept, goStart, matchDone;
  logic [IDX_W-1:0]      keyIdx, dataIdx;

  assign keyFull  = (keyCnt_q == NW_C);
  assign dataFull = (dataCnt_q == NW_C);

  // A full data block with an incomplete key cannot progress, so input is
  // refused until reset. Input is also refused while reset is held.
  assign loadReady = (state_q == LOAD) && !(dataFull && !keyFull);
  assign in_ready  = rst && loadReady;

  assign keyAccept  = in_valid && loadReady && in_is_key;
  assign dataAccept = in_valid && loadReady && !in_is_key;

  // A key word arriving after a complete key starts a fresh key at word 0.
  assign keyIdx  = keyFull ? '0 : keyCnt_q[IDX_W-1:0];
  assign dataIdx = dataCnt_q[IDX_W-1:0];

  // Next-cycle counter values let the start pulse follow the last accepted
  // operand word by exactly one cycle.
  always_comb begin
    keyCnt_d  = keyCnt_q;
    dataCnt_d = dataCnt_q;
    mode_d    = mode_q;
    if (keyAccept) begin
      keyCnt_d = keyFull ? CNT_W'(1) : keyCnt_q + CNT_W'(1);
    end
    if (dataAccept) begin
      dataCnt_d = dataCnt_q + CNT_W'(1);
      if (dataCnt_q == LAST_DATA) begin
        mode_d = in_mode;
      end
    end
  end

  assign goStart   = (keyCnt_d == NW_C) && (dataCnt_d == NW_C);
  assign matchDone = mode_q ? done_decyption : done_encryption;

  // Main FSM: collects operands, pulses the core, waits for the matching
  // done (bounded by the timeout) and then streams the result out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LOAD;
      keyCnt_q     <= '0;
      dataCnt_q    <= '0;
      outCnt_q     <= '0;
      timer_q      <= '0;
      mode_q       <= 1'b0;
      keyReg_q     <= '0;
      dataReg_q    <= '0;
      outReg_q     <= '0;
      startEnc_q   <= 1'b0;
      startDec_q   <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          keyCnt_q  <= keyCnt_d;
          dataCnt_q <= dataCnt_d;
          mode_q    <= mode_d;
          for (int i = 0; i < NW; i++) begin
            if (keyAccept && (keyIdx == IDX_W'(i))) begin
              keyReg_q[DATA_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH] <= in_data;
            end
            if (dataAccept && (dataIdx == IDX_W'(i))) begin
              dataReg_q[DATA_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH] <= in_data;
            end
          end
          if (goStart) begin
            state_q      <= START;
            startEnc_q   <= !mode_d;
            startDec_q   <= mode_d;
            errTimeout_q <= 1'b0;
          end
        end
        START: begin
          startEnc_q <= 1'b0;
          startDec_q <= 1'b0;
          timer_q    <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (matchDone) begin
            outReg_q <= mode_q ? plaintext_decryption : cyphertext_encryption;
            outCnt_q <= '0;
            state_q  <= DRAIN;
          end else if (timer_q == TMR_LAST) begin
            errTimeout_q <= 1'b1;
            dataCnt_q    <= '0;
            state_q      <= LOAD;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (outCnt_q == LAST_OUT) begin
              outCnt_q  <= '0;
              dataCnt_q <= '0;
              state_q   <= LOAD;
            end else begin
              outCnt_q <= outCnt_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Result word selection, MSB word first.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NW; i++) begin
      if (outCnt_q == IDX_W'(i)) begin
        out_data = outReg_q[DATA_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH];
      end
    end
  end

  assign out_valid             = (state_q == DRAIN);
  assign busy                  = (state_q != LOAD);
  assign err_timeout           = errTimeout_q;
  assign start_encryption      = startEnc_q;
  assign start_decryption      = startDec_q;
  assign plaintext_encryption  = dataReg_q;
  assign cyphertext_decryption = dataReg_q;
  assign key_encryption        = keyReg_q;

endmodule
